// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path: opcodes, FSM state
// encodings, datapath select encodings and the control-vector struct.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTEX   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_IMMEX  = 4'd9,
        S_IMMWB  = 4'd10,
        S_JUMP   = 4'd11,
        S_TRAP   = 4'd15
    } state_t;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_SUB  = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;
    localparam logic [1:0] ALUOP_IMM  = 2'b11;

    localparam logic [1:0] IMM_AND = 2'b00;
    localparam logic [1:0] IMM_OR  = 2'b01;
    localparam logic [1:0] IMM_SLT = 2'b10;

    localparam logic [1:0] PCSRC_ALURES = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMMSH2 = 2'b11;

    typedef struct packed {
        logic       pcwrite;
        logic       branch;
        logic       bne;
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
        logic [1:0] imm_ctl;
        logic       zeroext;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/mc_outdec.sv
// Combinational state-to-control-vector decoder. Only FETCH looks at the
// memory gate; BRANCH and IMMEX refine their controls by the held opcode.
module mc_outdec
    import mips_pkg::*;
(
    input  state_t      state_i,
    input  logic [5:0]  op_i,
    input  logic        mem_go_i,
    output ctrl_t       ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_o.iord    = 1'b0;
                ctrl_o.alusrcb = SRCB_FOUR;
                ctrl_o.aluop   = ALUOP_ADD;
                ctrl_o.pcsrc   = PCSRC_ALURES;
                ctrl_o.irwrite = mem_go_i;
                ctrl_o.pcwrite = mem_go_i;
            end
            S_DECODE: begin
                ctrl_o.alusrcb = SRCB_IMMSH2;
                ctrl_o.aluop   = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.alusrcb = SRCB_IMM;
                ctrl_o.aluop   = ALUOP_ADD;
            end
            S_MEMRD: ctrl_o.iord = 1'b1;
            S_MEMWB: begin
                ctrl_o.memtoreg = 1'b1;
                ctrl_o.regwrite = 1'b1;
            end
            S_MEMWR: begin
                ctrl_o.iord     = 1'b1;
                ctrl_o.memwrite = 1'b1;
            end
            S_RTEX: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.alusrcb = SRCB_B;
                ctrl_o.aluop   = ALUOP_FUNC;
            end
            S_ALUWB: begin
                ctrl_o.regdst   = 1'b1;
                ctrl_o.regwrite = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.alusrcb = SRCB_B;
                ctrl_o.aluop   = ALUOP_SUB;
                ctrl_o.pcsrc   = PCSRC_ALUOUT;
                ctrl_o.branch  = 1'b1;
                ctrl_o.bne     = (op_i == OP_BNE);
            end
            S_IMMEX: begin
                ctrl_o.alusrca = 1'b1;
                ctrl_o.alusrcb = SRCB_IMM;
                // ANDI/ORI/SLTI bypass the funct decoder; ADDI is a plain add
                case (op_i)
                    OP_ANDI: begin
                        ctrl_o.aluop   = ALUOP_IMM;
                        ctrl_o.imm_ctl = IMM_AND;
                        ctrl_o.zeroext = 1'b1;
                    end
                    OP_ORI: begin
                        ctrl_o.aluop   = ALUOP_IMM;
                        ctrl_o.imm_ctl = IMM_OR;
                        ctrl_o.zeroext = 1'b1;
                    end
                    OP_SLTI: begin
                        ctrl_o.aluop   = ALUOP_IMM;
                        ctrl_o.imm_ctl = IMM_SLT;
                    end
                    default: ctrl_o.aluop = ALUOP_ADD;
                endcase
            end
            S_IMMWB: ctrl_o.regwrite = 1'b1;
            S_JUMP: begin
                ctrl_o.pcsrc   = PCSRC_JUMP;
                ctrl_o.pcwrite = 1'b1;
            end
            S_TRAP: ctrl_o.illegal = 1'b1;
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/writeback and
// drives datapath enables through the mc_outdec control-vector decoder.
module mc_controller
    import mips_pkg::*;
#(
    parameter bit WAIT_EN = 1'b1,
    parameter bit EXT_OPS = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       pcwrite,
    output logic       branch,
    output logic       bne,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [1:0] aluop,
    output logic [1:0] imm_ctl,
    output logic       zeroext,
    output logic       illegal,
    output logic [3:0] state
);

    state_t state_q, state_d;
    ctrl_t  ctrl;
    logic   memGo;

    assign memGo = WAIT_EN ? mem_ready : 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // TRAP is absorbing: only the async reset brings the FSM back to FETCH
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (memGo) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_RTYPE:               state_d = S_RTEX;
                    OP_LW, OP_SW:           state_d = S_MEMADR;
                    OP_BEQ:                 state_d = S_BRANCH;
                    OP_BNE:                 state_d = EXT_OPS ? S_BRANCH : S_TRAP;
                    OP_ADDI:                state_d = S_IMMEX;
                    OP_ANDI, OP_ORI, OP_SLTI: state_d = EXT_OPS ? S_IMMEX : S_TRAP;
                    OP_J:                   state_d = S_JUMP;
                    default:                state_d = S_TRAP;
                endcase
            end
            S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (memGo) state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  if (memGo) state_d = S_FETCH;
            S_RTEX:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_IMMEX:  state_d = S_IMMWB;
            S_IMMWB:  state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_FETCH;
        endcase
    end

    mc_outdec u_outdec (
        .state_i  (state_q),
        .op_i     (op),
        .mem_go_i (memGo),
        .ctrl_o   (ctrl)
    );

    assign pcwrite  = ctrl.pcwrite;
    assign branch   = ctrl.branch;
    assign bne      = ctrl.bne;
    assign iord     = ctrl.iord;
    assign memwrite = ctrl.memwrite;
    assign irwrite  = ctrl.irwrite;
    assign regwrite = ctrl.regwrite;
    assign regdst   = ctrl.regdst;
    assign memtoreg = ctrl.memtoreg;
    assign alusrca  = ctrl.alusrca;
    assign alusrcb  = ctrl.alusrcb;
    assign pcsrc    = ctrl.pcsrc;
    assign aluop    = ctrl.aluop;
    assign imm_ctl  = ctrl.imm_ctl;
    assign zeroext  = ctrl.zeroext;
    assign illegal  = ctrl.illegal;
    assign state    = state_q;

endmodule

// File: tb/tb_mc_controller.sv
// Directed testbench for mc_controller: a full-featured instance plus a second
// instance with WAIT_EN = 0 and EXT_OPS = 0, with hand-computed expectations.
module tb_mc_controller;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;

    logic       clk;
    logic       reset;
    logic [5:0] op;
    logic       mem_ready;
    logic       pcwrite, branch, bne, iord, memwrite, irwrite, regwrite;
    logic       regdst, memtoreg, alusrca, zeroext, illegal;
    logic [1:0] alusrcb, pcsrc, aluop, imm_ctl;
    logic [3:0] state;

    logic [5:0] op2;
    logic       memReady2;
    logic       pcwrite2, branch2, bne2, iord2, memwrite2, irwrite2, regwrite2;
    logic       regdst2, memtoreg2, alusrca2, zeroext2, illegal2;
    logic [1:0] alusrcb2, pcsrc2, aluop2, immCtl2;
    logic [3:0] state2;

    int testsRun = 0;
    int testsFailed = 0;

    int lwState[5]    = '{1, 2, 3, 4, 0};
    int lwRegwrite[5] = '{0, 0, 0, 1, 0};
    int lwMemtoreg[5] = '{0, 0, 0, 1, 0};

    logic [5:0] immOp[4]  = '{OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI};
    int immAluop[4]       = '{0, 3, 3, 3};
    int immCtl[4]         = '{0, 0, 1, 2};
    int immZext[4]        = '{0, 1, 1, 0};

    mc_controller #(.WAIT_EN(1'b1), .EXT_OPS(1'b1)) dut (
        .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
        .pcwrite(pcwrite), .branch(branch), .bne(bne), .iord(iord),
        .memwrite(memwrite), .irwrite(irwrite), .regwrite(regwrite),
        .regdst(regdst), .memtoreg(memtoreg), .alusrca(alusrca),
        .alusrcb(alusrcb), .pcsrc(pcsrc), .aluop(aluop), .imm_ctl(imm_ctl),
        .zeroext(zeroext), .illegal(illegal), .state(state)
    );

    mc_controller #(.WAIT_EN(1'b0), .EXT_OPS(1'b0)) dutBase (
        .clk(clk), .reset(reset), .op(op2), .mem_ready(memReady2),
        .pcwrite(pcwrite2), .branch(branch2), .bne(bne2), .iord(iord2),
        .memwrite(memwrite2), .irwrite(irwrite2), .regwrite(regwrite2),
        .regdst(regdst2), .memtoreg(memtoreg2), .alusrca(alusrca2),
        .alusrcb(alusrcb2), .pcsrc(pcsrc2), .aluop(aluop2), .imm_ctl(immCtl2),
        .zeroext(zeroext2), .illegal(illegal2), .state(state2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input int actual, input int expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Advance one clock and settle just past the rising edge
    task automatic applyStimulus();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int memCount;

        reset = 1'b1; op = OP_LW; mem_ready = 1'b1;
        op2 = OP_J; memReady2 = 1'b0;
        applyStimulus();
        applyStimulus();
        reset = 1'b0;
        #1;
        checkOutput("reset_state", int'(state), 0);
        checkOutput("reset_illegal", int'(illegal), 0);
        checkOutput("reset_memwrite", int'(memwrite), 0);
        checkOutput("fetch_irwrite", int'(irwrite), 1);
        checkOutput("fetch_pcwrite", int'(pcwrite), 1);
        checkOutput("fetch_alusrcb", int'(alusrcb), 1);

        for (int i = 0; i < 5; i++) begin
            applyStimulus();
            checkOutput($sformatf("lw_state%0d", i), int'(state), lwState[i]);
            checkOutput($sformatf("lw_regwrite%0d", i), int'(regwrite), lwRegwrite[i]);
            checkOutput($sformatf("lw_memtoreg%0d", i), int'(memtoreg), lwMemtoreg[i]);
            if (lwState[i] == 3) checkOutput("lw_memrd_iord", int'(iord), 1);
        end

        mem_ready = 1'b0; op = OP_SW;
        #1;
        checkOutput("wait_state0", int'(state), 0);
        checkOutput("wait_irwrite0", int'(irwrite), 0);
        checkOutput("wait_pcwrite0", int'(pcwrite), 0);
        applyStimulus();
        checkOutput("wait_state1", int'(state), 0);
        checkOutput("wait_irwrite1", int'(irwrite), 0);
        mem_ready = 1'b1;
        #1;
        checkOutput("ready_irwrite", int'(irwrite), 1);
        checkOutput("ready_pcwrite", int'(pcwrite), 1);
        applyStimulus();
        checkOutput("sw_decode", int'(state), 1);
        checkOutput("decode_alusrcb", int'(alusrcb), 3);
        checkOutput("decode_irwrite", int'(irwrite), 0);
        applyStimulus();
        checkOutput("sw_memadr", int'(state), 2);
        checkOutput("memadr_alusrca", int'(alusrca), 1);
        checkOutput("memadr_alusrcb", int'(alusrcb), 2);
        mem_ready = 1'b0;
        applyStimulus();
        checkOutput("sw_memwr", int'(state), 5);
        memCount = 0;
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 3);
            #1;
            if (memwrite) memCount++;
            applyStimulus();
        end
        checkOutput("sw_memwrite_cycles", memCount, 4);
        checkOutput("sw_back_fetch", int'(state), 0);
        checkOutput("fetch_memwrite", int'(memwrite), 0);

        op = OP_SW;
        applyStimulus();
        applyStimulus();
        mem_ready = 1'b0;
        applyStimulus();
        checkOutput("rst_pre_state", int'(state), 5);
        checkOutput("rst_pre_memwrite", int'(memwrite), 1);
        #2 reset = 1'b1;
        #1;
        checkOutput("rst_mid_state", int'(state), 0);
        checkOutput("rst_mid_memwrite", int'(memwrite), 0);
        checkOutput("rst_mid_illegal", int'(illegal), 0);
        reset = 1'b0;
        mem_ready = 1'b1;

        op = OP_BNE;
        applyStimulus();
        applyStimulus();
        checkOutput("bne_state", int'(state), 8);
        checkOutput("bne_branch", int'(branch), 1);
        checkOutput("bne_bne", int'(bne), 1);
        checkOutput("bne_pcsrc", int'(pcsrc), 1);
        checkOutput("bne_aluop", int'(aluop), 1);
        applyStimulus();
        checkOutput("bne_fetch", int'(state), 0);
        op = OP_BEQ;
        applyStimulus();
        applyStimulus();
        checkOutput("beq_state", int'(state), 8);
        checkOutput("beq_bne", int'(bne), 0);
        checkOutput("beq_branch", int'(branch), 1);
        applyStimulus();

        for (int i = 0; i < 4; i++) begin
            op = immOp[i];
            applyStimulus();
            applyStimulus();
            checkOutput($sformatf("imm%0d_state", i), int'(state), 9);
            checkOutput($sformatf("imm%0d_aluop", i), int'(aluop), immAluop[i]);
            checkOutput($sformatf("imm%0d_immctl", i), int'(imm_ctl), immCtl[i]);
            checkOutput($sformatf("imm%0d_zeroext", i), int'(zeroext), immZext[i]);
            checkOutput($sformatf("imm%0d_alusrcb", i), int'(alusrcb), 2);
            applyStimulus();
            checkOutput($sformatf("imm%0d_wb_state", i), int'(state), 10);
            checkOutput($sformatf("imm%0d_regwrite", i), int'(regwrite), 1);
            checkOutput($sformatf("imm%0d_regdst", i), int'(regdst), 0);
            applyStimulus();
            checkOutput($sformatf("imm%0d_fetch", i), int'(state), 0);
        end

        op = OP_RTYPE;
        applyStimulus();
        applyStimulus();
        checkOutput("rt_state", int'(state), 6);
        checkOutput("rt_aluop", int'(aluop), 2);
        checkOutput("rt_alusrcb", int'(alusrcb), 0);
        applyStimulus();
        checkOutput("rt_wb_state", int'(state), 7);
        checkOutput("rt_regdst", int'(regdst), 1);
        checkOutput("rt_regwrite", int'(regwrite), 1);
        applyStimulus();

        op = OP_J;
        applyStimulus();
        applyStimulus();
        checkOutput("j_state", int'(state), 11);
        checkOutput("j_pcsrc", int'(pcsrc), 2);
        checkOutput("j_pcwrite", int'(pcwrite), 1);
        applyStimulus();
        checkOutput("j_fetch", int'(state), 0);

        op = 6'b111111;
        applyStimulus();
        applyStimulus();
        checkOutput("trap_state", int'(state), 15);
        checkOutput("trap_illegal", int'(illegal), 1);
        for (int i = 0; i < 10; i++) begin
            applyStimulus();
            checkOutput($sformatf("trap_hold%0d", i), int'(state), 15);
            checkOutput($sformatf("trap_enables%0d", i),
                        int'({regwrite, memwrite, irwrite, pcwrite}), 0);
        end

        reset = 1'b1; op = OP_J; op2 = OP_SW; memReady2 = 1'b0;
        applyStimulus();
        reset = 1'b0;
        #1;
        checkOutput("rst_clear_state", int'(state), 0);
        checkOutput("rst_clear_illegal", int'(illegal), 0);
        checkOutput("base_reset_state", int'(state2), 0);
        checkOutput("base_fetch_irwrite", int'(irwrite2), 1);
        applyStimulus();
        checkOutput("base_decode", int'(state2), 1);
        applyStimulus();
        checkOutput("base_memadr", int'(state2), 2);
        applyStimulus();
        checkOutput("base_memwr", int'(state2), 5);
        checkOutput("base_memwrite", int'(memwrite2), 1);
        applyStimulus();
        checkOutput("base_sw_fetch", int'(state2), 0);
        op2 = OP_BNE;
        applyStimulus();
        applyStimulus();
        checkOutput("base_bne_trap", int'(state2), 15);
        checkOutput("base_bne_illegal", int'(illegal2), 1);
        checkOutput("base_bne_branch", int'(branch2), 0);
        applyStimulus();
        applyStimulus();
        checkOutput("base_trap_hold", int'(state2), 15);
        reset = 1'b1;
        #1;
        checkOutput("base_rst_state", int'(state2), 0);
        checkOutput("base_rst_illegal", int'(illegal2), 0);
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/mc_controller.md
Name: mc_controller

Overview:
Multicycle MIPS control unit: a Moore FSM that sequences FETCH/DECODE/execute/writeback per instruction and drives datapath enables and muxes.
- Successor to the single-cycle combinational main decoder.
- Adds a memory wait handshake, optional extended opcodes (BNE, ANDI, ORI, SLTI) and a sticky illegal-instruction trap.
- Sits between the instruction register opcode field and the multicycle datapath.
- The existing ALU decoder consumes `aluop`.

Parameters:
- WAIT_EN, 1: 1 = FETCH/MEMRD/MEMWR stall until mem_ready; 0 = mem_ready ignored, memory is single-cycle.
- EXT_OPS, 1: 1 = BNE/ANDI/ORI/SLTI decoded; 0 = those opcodes trap as illegal.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high
- op  in  6  instr[31:26] from instruction register
- mem_ready  in  1  memory completes access this cycle
- pcwrite  out  1  unconditional PC load
- branch  out  1  conditional PC load on zero
- bne  out  1  invert zero sense for branch
- iord  out  1  memory address mux: 0 = PC, 1 = ALUOut
- memwrite  out  1  memory write strobe
- irwrite  out  1  instruction register load
- regwrite  out  1  register file write
- regdst  out  1  0 = rt, 1 = rd
- memtoreg  out  1  0 = ALUOut, 1 = Data register
- alusrca  out  1  0 = PC, 1 = A
- alusrcb  out  2  00 = B, 01 = 4, 10 = SignImm/ZeroImm, 11 = SignImm<<2
- pcsrc  out  2  00 = ALUResult, 01 = ALUOut, 10 = jump target
- aluop  out  2  00 = add, 01 = sub, 10 = funct, 11 = use imm_ctl
- imm_ctl  out  2  00 = and, 01 = or, 10 = slt (valid when aluop = 11)
- zeroext  out  1  immediate zero-extended (ANDI/ORI)
- illegal  out  1  sticky trap flag
- state  out  4  current state encoding (debug/verification)

Behaviour:
- State encoding (4 bits):
  - FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5
  - RTEX 6, ALUWB 7, BRANCH 8, IMMEX 9, IMMWB 10, JUMP 11, TRAP 15
- Reset (async): state = FETCH, illegal = 0.
- All outputs are pure functions of state (Moore), except irwrite/pcwrite in FETCH, which are gated by mem_ready.
- Any output not listed for a state is 0.
- FETCH:
  - iord = 0, alusrcb = 01, aluop = 00, pcsrc = 00.
  - irwrite = pcwrite = (WAIT_EN ? mem_ready : 1).
  - Advance to DECODE only when the gate is true; otherwise hold.
- DECODE:
  - alusrcb = 11, aluop = 00.
  - Next state by op:
    - 000000 → RTEX
    - 100011 / 101011 → MEMADR
    - 000100 → BRANCH
    - 000101 → BRANCH when EXT_OPS
    - 001000 → IMMEX
    - 001100 / 001101 / 001010 → IMMEX when EXT_OPS
    - 000010 → JUMP
    - anything else → TRAP
- MEMADR: alusrca = 1, alusrcb = 10, aluop = 00. Next: MEMRD if LW, MEMWR if SW.
- MEMRD: iord = 1. Holds until mem_ready (WAIT_EN = 1), then MEMWB.
- MEMWB: regdst = 0, memtoreg = 1, regwrite = 1. Next: FETCH.
- MEMWR:
  - iord = 1, memwrite = 1 for every cycle in the state.
  - Exit to FETCH on mem_ready (or immediately when WAIT_EN = 0).
- RTEX: alusrca = 1, alusrcb = 00, aluop = 10. Next: ALUWB.
- ALUWB: regdst = 1, regwrite = 1. Next: FETCH.
- BRANCH:
  - alusrca = 1, alusrcb = 00, aluop = 01, pcsrc = 01, branch = 1.
  - bne = 1 iff op = 000101.
  - Next: FETCH.
- IMMEX:
  - alusrca = 1, alusrcb = 10.
  - ADDI: aluop = 00.
  - ANDI: aluop = 11, imm_ctl = 00, zeroext = 1.
  - ORI: aluop = 11, imm_ctl = 01, zeroext = 1.
  - SLTI: aluop = 11, imm_ctl = 10.
  - Next: IMMWB.
- IMMWB: regdst = 0, regwrite = 1. Next: FETCH.
- JUMP: pcsrc = 10, pcwrite = 1. Next: FETCH.
- TRAP:
  - Absorbing; all enables 0; illegal = 1.
  - Left only by reset.
- op stability: op is sampled from the instruction register. It stays stable after DECODE because irwrite is only asserted in FETCH.
- Reset mid-memory access: state returns to FETCH immediately, memwrite drops combinationally with state.
- Cycle counts with mem_ready always 1:
  - LW 5; SW 4; R-type 4; ADDI/ANDI/ORI/SLTI 4; BEQ/BNE 3; J 3.

Decomposition:
- Shared package mips_pkg:
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI, OP_J)
  - state encodings
  - aluop/imm_ctl/pcsrc/alusrcb encodings
- One sub-module is natural: mc_outdec, a combinational state → control-vector decoder. It keeps the FSM next-state logic separate from output encoding.

Test Plan:
- Reset mid-MEMWR (state = 5) → state = 0 and memwrite = 0 within the same cycle; illegal = 0.
- LW (op = 100011), mem_ready tied 1 → state sequence 0, 1, 2, 3, 4, 0; regwrite = 1 only in state 4 with memtoreg = 1.
- SW with WAIT_EN = 1, mem_ready low 3 cycles in MEMWR → memwrite = 1 for exactly 4 cycles, then state = 0.
- FETCH with mem_ready low 2 cycles → irwrite = pcwrite = 0 while waiting, 1 on the ready cycle, then DECODE.
- BNE (op = 000101) with EXT_OPS = 1 → BRANCH with branch = 1, bne = 1, pcsrc = 01. With EXT_OPS = 0 → TRAP, illegal = 1, held until reset.
- ORI (op = 001101) → IMMEX with aluop = 11, imm_ctl = 01, zeroext = 1; IMMWB with regwrite = 1, regdst = 0.
- op = 111111 → TRAP (state = 15); all write enables 0 for 10 subsequent cycles.
